rgbled_chain_ctrl: RTL

Parametrised WS281x-compatible RGB LED chain controller. It replaces the fixed single-LED "drive to off" driver on the board's RGB LED output with a NumLeds-deep colour store, global brightness scaling, and one-shot or continuous refresh. It runs on main_clk_buf. Its serial output is a registered, active-high data line; the top level applies any pad inversion.

---
 rtl/rgbled_chain_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rgbled_chain_ctrl.sv
// WS281x RGB LED chain controller: colour store, brightness scaling,
// one-shot or continuous frame refresh on a registered serial line.
module rgbled_chain_ctrl #(
  parameter int unsigned NumLeds = 2,
  parameter int unsigned ClkFreq = 25_000_000,
  parameter int unsigned T0hNs   = 400,
  parameter int unsigned T1hNs   = 800,
  parameter int unsigned BitNs   = 1250,
  parameter int unsigned ResetUs = 80,
  localparam int unsigned IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            main_clk_buf,
  input  logic            rst_sys_n,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [23:0]     wr_rgb_i,
  input  logic [7:0]      brightness_i,
  input  logic            refresh_i,
  input  logic            auto_refresh_i,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            dout_o
);

  localparam longint unsigned KHz = 64'(ClkFreq / 1000);
  localparam int unsigned T0hCyc =
    int'((KHz * 64'(T0hNs)) / 64'd1_000_000);
  localparam int unsigned T1hCyc =
    int'((KHz * 64'(T1hNs)) / 64'd1_000_000);
  localparam int unsigned BitCyc =
    int'((KHz * 64'(BitNs)) / 64'd1_000_000);
  localparam int unsigned LatchCyc =
    int'((KHz * 64'(ResetUs) * 64'd1000) / 64'd1_000_000);
  localparam int unsigned CntMax =
    (LatchCyc > BitCyc) ? LatchCyc : BitCyc;
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] BitLast   = CntW'(BitCyc - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(LatchCyc - 1);
  localparam logic [CntW-1:0] T0h       = CntW'(T0hCyc);
  localparam logic [CntW-1:0] T1h       = CntW'(T1hCyc);
  localparam logic [IdxW-1:0] LedLast   = IdxW'(NumLeds - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, LATCH
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [IdxW-1:0] led_q, led_d;
  logic [23:0]     sh_q, sh_d;
  logic [7:0]      br_q, br_d;
  logic            pend_q, pend_d;
  logic            dout_q, dout_d;
  logic [23:0]     col_q [NumLeds];

  logic [IdxW-1:0] rd_idx;
  logic [7:0]      scale_b;
  logic [23:0]     rd_rgb;
  logic [23:0]     scaled;

  function automatic logic [7:0] scl(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction

  // LOAD reads LED 0 with the live brightness; SHIFT prefetches the next LED
  assign rd_idx  = (state_q == LOAD || led_q == LedLast) ?
                   '0 : led_q + IdxW'(1);
  assign scale_b = (state_q == LOAD) ? brightness_i : br_q;
  assign rd_rgb  = col_q[rd_idx];
  assign scaled  = {scl(rd_rgb[15:8], scale_b),
                    scl(rd_rgb[23:16], scale_b),
                    scl(rd_rgb[7:0], scale_b)};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    led_d        = led_q;
    sh_d         = sh_q;
    br_d         = br_q;
    pend_d       = pend_q;
    frame_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (refresh_i | pend_q | auto_refresh_i) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
        br_d    = brightness_i;
        sh_d    = scaled;
        cnt_d   = '0;
        bit_d   = '0;
        led_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (led_q == LedLast) begin
              state_d = LATCH;
            end else begin
              led_d = led_q + IdxW'(1);
              sh_d  = scaled;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            sh_d  = {sh_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == LatchLast) begin
          frame_done_o = 1'b1;
          if (auto_refresh_i | pend_q | refresh_i) state_d = LOAD;
          else state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) pend_d = 1'b0;
    else if (refresh_i && state_q != IDLE) pend_d = 1'b1;
    // output register follows the next state so it lines up with the bit slot
    dout_d = (state_d == SHIFT) &&
             (cnt_d < (sh_d[23] ? T1h : T0h));
  end

  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      sh_q    <= '0;
      br_q    <= '0;
      pend_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      sh_q    <= sh_d;
      br_q    <= br_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < NumLeds; i++) col_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumLeds; i++) begin
        if (wr_en_i && wr_idx_i == IdxW'(i)) col_q[i] <= wr_rgb_i;
      end
    end
  end

  assign busy_o = (state_q != IDLE);
  assign dout_o = dout_q;

endmodule
